// File: rtl/fifo_pkg.sv
// Shared widths and types for the FIFO and its read-side stream adapter.
package fifo_pkg;

   localparam int FIFO_M           = 4;
   localparam int READER_BUF_DEPTH = 3;

   typedef logic [1:0] occ_t;

   // Advance a reader buffer pointer, wrapping after the last entry.
   function automatic occ_t ptr_inc(input occ_t p);
      return (p == occ_t'(READER_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Three-entry circular buffer absorbing the FIFO read latency.
// Valid and head data come only from registers, so the stream side has no input-to-output path.
module fifo_reader_buf
   import fifo_pkg::*;
#(
   parameter int M = FIFO_M
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_push,
   input  logic [M-1:0] i_push_data,
   input  logic         i_pop,
   output occ_t         o_occ,
   output logic         o_valid,
   output logic [M-1:0] o_data
);

   logic [M-1:0] r_mem [READER_BUF_DEPTH];
   occ_t         r_rd_ptr;
   occ_t         r_wr_ptr;
   occ_t         r_occ;
   logic         r_valid;
   logic         w_pop;
   occ_t         w_occ_nxt;
   logic [M-1:0] w_head;

   assign w_pop = i_pop && r_valid;

   // Next occupancy: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      w_occ_nxt = r_occ;
      case ({i_push, w_pop})
         2'b10:   w_occ_nxt = r_occ + 2'd1;
         2'b01:   w_occ_nxt = r_occ - 2'd1;
         default: w_occ_nxt = r_occ;
      endcase
   end

   // Head-of-queue select.
   always_comb begin
      w_head = r_mem[0];
      case (r_rd_ptr)
         2'd1:    w_head = r_mem[1];
         2'd2:    w_head = r_mem[2];
         default: w_head = r_mem[0];
      endcase
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < READER_BUF_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rd_ptr <= 2'd0;
         r_wr_ptr <= 2'd0;
         r_occ    <= 2'd0;
         r_valid  <= 1'b0;
      end else begin
         for (int i = 0; i < READER_BUF_DEPTH; i++) begin
            if (i_push && (r_wr_ptr == occ_t'(i))) begin
               r_mem[i] <= i_push_data;
            end
         end
         if (i_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_occ   <= w_occ_nxt;
         r_valid <= (w_occ_nxt != 2'd0);
      end
   end

   assign o_occ   = r_occ;
   assign o_valid = r_valid;
   assign o_data  = w_head;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from the synchronous FIFO and presents them on a valid/ready stream,
// counting completed transfers.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int M  = FIFO_M,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en,
   input  logic          fifo_empty,
   input  logic [M-1:0]  fifo_rd,
   output logic          fifo_re,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [M-1:0]  out_data,
   output logic [CW-1:0] xfer_cnt
);

   logic          r_inflight;
   logic [CW-1:0] r_xfer_cnt;
   occ_t          w_occ;
   logic [2:0]    w_outstanding;
   logic          w_xfer;

   // Issue only with room for every outstanding word; out_ready is deliberately
   // kept out of this path so the read enable never depends on the sink.
   assign w_outstanding = {1'b0, w_occ} + {2'b00, r_inflight};
   assign fifo_re       = reset_n && en && !fifo_empty
                          && (w_outstanding < 3'(READER_BUF_DEPTH));
   assign w_xfer        = out_valid && out_ready;

   // In-flight flag and transfer counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_inflight <= 1'b0;
         r_xfer_cnt <= '0;
      end else begin
         r_inflight <= fifo_re;
         if (w_xfer) begin
            r_xfer_cnt <= r_xfer_cnt + CW'(1);
         end
      end
   end

   fifo_reader_buf #(
      .M (M)
   ) u_buf (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (r_inflight),
      .i_push_data (fifo_rd),
      .i_pop       (out_ready),
      .o_occ       (w_occ),
      .o_valid     (out_valid),
      .o_data      (out_data)
   );

   assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: behavioural FIFO, queue scoreboard, a cycle table for the
// streaming case, directed corner cases and a randomized phase.
module tb_fifo_stream_reader;

   localparam int M  = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          fifo_rst_n = 1'b1;
   logic          en = 1'b0;
   logic          out_ready = 1'b0;
   logic          wr_req = 1'b0;
   logic [M-1:0]  wr_data = '0;
   logic          fifo_empty = 1'b1;
   logic [M-1:0]  fifo_rd = '0;
   logic          fifo_re;
   logic          out_valid;
   logic [M-1:0]  out_data;
   logic [CW-1:0] xfer_cnt;

   int            n_tests = 0;
   int            n_fail = 0;

   logic [M-1:0]  fq[$];
   logic [M-1:0]  exp_q[$];
   int            exp_cnt = 0;
   int            out_n = 0;
   int            re_pulses = 0;
   bit            prev_hold = 1'b0;
   logic [M-1:0]  prev_data = '0;

   typedef struct {
      logic          en;
      logic          exp_re;
      logic          exp_valid;
      logic [M-1:0]  exp_data;
      logic [CW-1:0] exp_cnt;
   } vec_t;
   vec_t tbl[12];

   always #5 clk = ~clk;

   fifo_stream_reader #(.M(M), .CW(CW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_re    (fifo_re),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .xfer_cnt   (xfer_cnt)
   );

   // Behavioural synchronous FIFO: registered read data, write visible next cycle.
   always @(posedge clk) begin
      if (!fifo_rst_n) begin
         fq.delete();
         fifo_rd <= '0;
      end else begin
         if (fifo_re && fq.size() > 0) fifo_rd <= fq.pop_front();
         if (wr_req) fq.push_back(wr_data);
      end
      fifo_empty <= (fq.size() == 0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle scoreboard, called at the falling edge before the next active edge.
   task automatic mon();
      if (!reset_n) begin
         check("re_in_reset", fifo_re, 0);
      end else begin
         check("xfer_cnt", xfer_cnt, exp_cnt % 65536);
         if (fifo_empty || !en) check("re_gated", fifo_re, 0);
         if (prev_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
         end
         if (fifo_re && !fifo_empty) begin
            out_n++;
            re_pulses++;
         end
         if (out_valid && out_ready) begin
            check("xfer_has_data", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("xfer_data", out_data, exp_q.pop_front());
            exp_cnt++;
            out_n--;
         end
         check("outstanding_le3", (out_n <= 3), 1);
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic fifo_write(input logic [M-1:0] d);
      wr_req  = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      cyc();
      wr_req  = 1'b0;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      fifo_rst_n = 1'b0;
      en         = 1'b0;
      wr_req     = 1'b0;
      cyc();
      cyc();
      exp_q.delete();
      exp_cnt    = 0;
      out_n      = 0;
      prev_hold  = 1'b0;
      reset_n    = 1'b1;
      fifo_rst_n = 1'b1;
   endtask

   task automatic drain(input int bound);
      en        = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < bound; i++) begin
         if (exp_q.size() == 0 && out_n == 0) break;
         cyc();
      end
      check("drain_empty", exp_q.size(), 0);
      check("drain_idle", out_valid, 0);
   endtask

   initial begin
      for (int k = 0; k < 12; k++) begin
         tbl[k].en        = 1'b1;
         tbl[k].exp_re    = (k <= 7);
         tbl[k].exp_valid = (k >= 2 && k <= 9);
         tbl[k].exp_data  = (k >= 2 && k <= 9) ? M'(k - 1) : '0;
         tbl[k].exp_cnt   = (k < 2) ? CW'(0) : ((k <= 10) ? CW'(k - 2) : CW'(8));
      end

      @(posedge clk);
      #1;

      // Reset held with en high and a non-empty FIFO.
      fifo_write(4'h1);
      fifo_write(4'h2);
      en        = 1'b1;
      out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_re", fifo_re, 0);
         check("rst_valid", out_valid, 0);
         check("rst_cnt", xfer_cnt, 0);
         check("rst_data", out_data, 0);
         @(posedge clk);
         #1;
      end

      // Continuous stream of 0x1..0x8, checked cycle by cycle.
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) fifo_write(M'(i));
      for (int k = 0; k < 12; k++) begin
         en = tbl[k].en;
         @(negedge clk);
         check("tbl_re", fifo_re, tbl[k].exp_re);
         check("tbl_valid", out_valid, tbl[k].exp_valid);
         if (tbl[k].exp_valid) check("tbl_data", out_data, tbl[k].exp_data);
         check("tbl_cnt", xfer_cnt, tbl[k].exp_cnt);
         mon();
         @(posedge clk);
         #1;
      end

      // Backpressure: only three reads outstanding, head held stable.
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) fifo_write(M'(i));
      en        = 1'b1;
      re_pulses = 0;
      repeat (10) cyc();
      check("bp_re_pulses", re_pulses, 3);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 4'h1);
      drain(40);
      check("bp_cnt", xfer_cnt, 8);

      // Empty FIFO: no reads, then a single word with two-cycle latency.
      do_reset();
      en        = 1'b1;
      out_ready = 1'b1;
      re_pulses = 0;
      repeat (10) cyc();
      check("empty_no_re", re_pulses, 0);
      fifo_write(4'hA);
      @(negedge clk);
      check("empty_re_rise", fifo_re, 1);
      mon();
      @(posedge clk);
      #1;
      @(negedge clk);
      check("empty_lat1_valid", out_valid, 0);
      mon();
      @(posedge clk);
      #1;
      @(negedge clk);
      check("empty_lat2_valid", out_valid, 1);
      check("empty_lat2_data", out_data, 4'hA);
      mon();
      @(posedge clk);
      #1;
      drain(10);

      // en gating after two reads.
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) fifo_write(M'(i));
      en        = 1'b1;
      re_pulses = 0;
      cyc();
      cyc();
      en = 1'b0;
      repeat (8) cyc();
      check("en_re_pulses", re_pulses, 2);
      check("en_cnt", xfer_cnt, 2);
      check("en_idle", out_valid, 0);
      drain(40);
      check("en_cnt_final", xfer_cnt, 8);

      // Reset with a full buffer discards everything.
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 6; i++) fifo_write(M'(i));
      en = 1'b1;
      repeat (4) cyc();
      out_ready = 1'b0;
      repeat (6) cyc();
      check("mid_full_valid", out_valid, 1);
      check("mid_pre_cnt", xfer_cnt, 2);
      reset_n    = 1'b0;
      fifo_rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_re", fifo_re, 0);
      @(posedge clk);
      #1;
      reset_n    = 1'b1;
      fifo_rst_n = 1'b1;
      exp_q.delete();
      exp_cnt   = 0;
      out_n     = 0;
      prev_hold = 1'b0;
      @(negedge clk);
      check("mid_post_valid", out_valid, 0);
      check("mid_post_cnt", xfer_cnt, 0);
      mon();
      @(posedge clk);
      #1;
      en        = 1'b1;
      out_ready = 1'b1;
      fifo_write(4'h5);
      cyc();
      cyc();
      @(negedge clk);
      check("mid_first_valid", out_valid, 1);
      check("mid_first_data", out_data, 4'h5);
      mon();
      @(posedge clk);
      #1;
      drain(10);

      // Randomized traffic against the scoreboard.
      do_reset();
      for (int n = 0; n < 500; n++) begin
         en        = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 1) == 1 && exp_q.size() < 10) begin
            fifo_write(M'($urandom));
         end else begin
            cyc();
         end
      end
      drain(80);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
